// File: rtl/adxl345_spi_model.sv
`timescale 1ns/1ps
// Behavioural ADXL345 accelerometer for board-level simulation of an SPI master.
// Latency: SPI edges seen 3 clk after the pin (2-flop sync + edge detect); INT pins 1 clk after source change.
// Backpressure: none; FIFO mode drops pushes when full, stream mode discards the oldest entry.
// Ports: clk/reset (sync, active-high); SAMPLE_IN axis samples (axis 0 in [15:0]);
//   G_SENSOR_SCLK/nCS SPI inputs (mode 3); G_SENSOR_SDA_SDIO MOSI or 3-wire data;
//   G_SENSOR_SDO 4-wire MISO; G_SENSOR_INT/INT2 interrupt outputs.
module adxl345_spi_model #(
  parameter int         CHANNELS   = 3,
  parameter int         FIFO_DEPTH = 32,
  parameter int         SAMPLE_DIV = 500,
  parameter logic [7:0] DEVID      = 8'hE5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [16*CHANNELS-1:0]  SAMPLE_IN,
  input  logic                    G_SENSOR_SCLK,
  input  logic                    G_SENSOR_nCS,
  inout  wire                     G_SENSOR_SDA_SDIO,
  inout  wire                     G_SENSOR_SDO,
  output logic                    G_SENSOR_INT,
  output logic                    G_SENSOR_INT2
);

  localparam int SW   = 16 * CHANNELS;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = 6;
  localparam int CNTW = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_t;

  // ---------------- SPI synchronisers and edge detect ----------------
  logic [1:0] sclk_sync, ncs_sync;
  logic       sclk_d, ncs_d;
  logic       sclk_s, ncs_s;
  logic       sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  // Reset to the idle-high level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= 2'b11;
      ncs_sync  <= 2'b11;
      sclk_d    <= 1'b1;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], G_SENSOR_SCLK};
      ncs_sync  <= {ncs_sync[0], G_SENSOR_nCS};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign ncs_s     = ncs_sync[1];
  assign sclk_rise = sclk_s & ~sclk_d & ~ncs_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~ncs_s;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  // ---------------- state ----------------
  spi_state_t     state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift_in, shift_out;
  logic           rnw, mb, touched, out_bit;
  logic [5:0]     addr;

  logic [7:0]     bw_rate, power_ctl, int_enable, int_map, data_format, fifo_ctl;

  logic [SW-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;
  logic [CNTW-1:0] sample_cnt;

  logic           sdi;
  logic [7:0]     byte_in, rd_data, int_source;
  logic [47:0]    head_ext;
  logic           wr_strobe, flush, pop_req, tick, measure;
  logic           head_reg;

  assign sdi       = G_SENSOR_SDA_SDIO;
  assign byte_in   = {shift_in[6:0], sdi};
  assign wr_strobe = (state == DATA) && !rnw && sclk_rise && (bit_cnt == 3'd7);
  assign flush     = wr_strobe && (addr == 6'h38);
  assign pop_req   = ncs_rise && (state == DATA) && rnw && touched;
  assign measure   = power_ctl[3];
  assign tick      = measure && (sample_cnt == CNTW'(SAMPLE_DIV - 1));
  assign head_reg  = (addr >= 6'h32) && (addr <= 6'h37);

  // ---------------- SPI FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_in  <= 8'h00;
      shift_out <= 8'h00;
      rnw       <= 1'b0;
      mb        <= 1'b0;
      addr      <= 6'h00;
      touched   <= 1'b0;
      out_bit   <= 1'b0;
    end else if (ncs_rise) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
    end else if (ncs_fall) begin
      state   <= CMD;
      bit_cnt <= 3'd0;
      touched <= 1'b0;
      out_bit <= 1'b0;
    end else begin
      if (sclk_rise && state != IDLE) begin
        shift_in <= byte_in;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (state == CMD) begin
            rnw   <= byte_in[7];
            mb    <= byte_in[6];
            addr  <= byte_in[5:0];
            state <= DATA;
          end else if (mb) begin
            addr <= addr + 6'd1;
          end
        end
      end
      // First falling edge of a byte fetches it and presents bit 7 at once.
      if (sclk_fall && state == DATA && rnw) begin
        if (bit_cnt == 3'd0) begin
          shift_out <= {rd_data[6:0], 1'b0};
          out_bit   <= rd_data[7];
          if (head_reg) touched <= 1'b1;
        end else begin
          shift_out <= {shift_out[6:0], 1'b0};
          out_bit   <= shift_out[7];
        end
      end
    end
  end

  // ---------------- register file ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      bw_rate     <= 8'h00;
      power_ctl   <= 8'h00;
      int_enable  <= 8'h00;
      int_map     <= 8'h00;
      data_format <= 8'h00;
      fifo_ctl    <= 8'h00;
    end else if (wr_strobe) begin
      case (addr)
        6'h2C: bw_rate     <= byte_in;
        6'h2D: power_ctl   <= byte_in;
        6'h2E: int_enable  <= byte_in;
        6'h2F: int_map     <= byte_in;
        6'h31: data_format <= byte_in;
        6'h38: fifo_ctl    <= byte_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    head_ext = '0;
    if (count != '0) head_ext[SW-1:0] = mem[rd_ptr];
  end

  assign int_source = {(count != '0), 5'b0, (count >= {1'b0, fifo_ctl[4:0]}), 1'b0};

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      6'h00: rd_data = DEVID;
      6'h2C: rd_data = bw_rate;
      6'h2D: rd_data = power_ctl;
      6'h2E: rd_data = int_enable;
      6'h2F: rd_data = int_map;
      6'h30: rd_data = int_source;
      6'h31: rd_data = data_format;
      6'h32: rd_data = head_ext[7:0];
      6'h33: rd_data = head_ext[15:8];
      6'h34: rd_data = head_ext[23:16];
      6'h35: rd_data = head_ext[31:24];
      6'h36: rd_data = head_ext[39:32];
      6'h37: rd_data = head_ext[47:40];
      6'h38: rd_data = fifo_ctl;
      6'h39: rd_data = {2'b00, count};
      default: rd_data = 8'h00;
    endcase
  end

  // ---------------- sample timer ----------------
  always_ff @(posedge clk) begin
    if (reset || !measure)      sample_cnt <= '0;
    else if (tick)              sample_cnt <= '0;
    else                        sample_cnt <= sample_cnt + 1'b1;
  end

  // ---------------- sample FIFO ----------------
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic           bypass, stream, full, do_pop, mem_we;
  logic [PW-1:0]  mem_wa, nxt_rd, nxt_wr;
  logic [CW-1:0]  nxt_cnt;

  assign bypass = (fifo_ctl[7] == fifo_ctl[6]);
  assign stream = (fifo_ctl[7:6] == 2'b10);
  assign full   = (count == CW'(FIFO_DEPTH));
  assign do_pop = pop_req && (count != '0);

  always_comb begin
    mem_we  = 1'b0;
    mem_wa  = wr_ptr;
    nxt_rd  = rd_ptr;
    nxt_wr  = wr_ptr;
    nxt_cnt = count;
    if (flush) begin
      nxt_rd  = '0;
      nxt_wr  = '0;
      nxt_cnt = '0;
    end else if (bypass) begin
      // Single entry: a push always lands on the head slot, a pop empties it.
      if (tick) begin
        mem_we  = 1'b1;
        mem_wa  = rd_ptr;
        nxt_wr  = ptr_inc(rd_ptr);
        nxt_cnt = CW'(1);
      end else if (do_pop) begin
        nxt_rd  = ptr_inc(rd_ptr);
        nxt_cnt = '0;
      end
    end else begin
      if (tick && (!full || stream || do_pop)) begin
        mem_we = 1'b1;
        nxt_wr = ptr_inc(wr_ptr);
        // Pop or stream-mode discard keeps the count; otherwise it grows.
        if (do_pop || full) nxt_rd  = ptr_inc(rd_ptr);
        else                nxt_cnt = count + 1'b1;
      end else if (do_pop) begin
        nxt_rd  = ptr_inc(rd_ptr);
        nxt_cnt = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= nxt_rd;
      wr_ptr <= nxt_wr;
      count  <= nxt_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= SAMPLE_IN;
  end

  // ---------------- interrupts and pins ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      G_SENSOR_INT  <= 1'b0;
      G_SENSOR_INT2 <= 1'b0;
    end else begin
      G_SENSOR_INT  <= |(int_source & int_enable & ~int_map);
      G_SENSOR_INT2 <= |(int_source & int_enable & int_map);
    end
  end

  logic read_oe;
  assign read_oe           = (state == DATA) && rnw;
  assign G_SENSOR_SDA_SDIO = (read_oe && data_format[6])  ? out_bit : 1'bz;
  assign G_SENSOR_SDO      = (read_oe && !data_format[6]) ? out_bit : 1'bz;

endmodule
